sync_fifo_ctrl: RTL and testbench

Single-clock controller that sequences the 8-entry FIFO register array and shares its write port between two producers. It arbitrates the producers round-robin and generates the array's `write_enable`/`write_addr`/`write_data` and `read_enable`/`read_addr`. It tracks occupancy and raises `rd_valid` in the cycle the array's registered `read_data` is valid. It sits between the producer/consumer logic and the array, with the array's two clock inputs tied to `clk`.

---
 rtl/sync_fifo_ctrl.sv | 125 ++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Controller for an 8-entry register-array FIFO with a registered read port.
// Two producers share the array write port through a round-robin arbiter; a
// single consumer pops entries. The controller owns the pointers, occupancy
// and status flags. It never touches array contents on reset.
//
// Ports
//   clk, rst                  : single clock, synchronous active-high reset
//   wr_req_a/b, wr_data_a/b   : producer requests and signed-byte data
//   wr_gnt_a/b                : combinational grants (write happens this cycle)
//   rd_req                    : consumer pop request
//   rd_valid                  : array read_data holds the popped entry
//   write_enable/addr/data    : array write port
//   read_enable/addr          : array read port (data returns next cycle)
//   full, empty, count        : registered occupancy status
//   ovf, unf                  : one-cycle pulses for refused write / pop
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req_a,
  input  logic [7:0]        wr_data_a,
  output logic              wr_gnt_a,
  input  logic              wr_req_b,
  input  logic [7:0]        wr_data_b,
  output logic              wr_gnt_b,
  input  logic              rd_req,
  output logic              rd_valid,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [7:0]        write_data,
  output logic              read_enable,
  output logic [ADDR_W-1:0] read_addr,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              unf
);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              prio_q, prio_d;
  logic              rd_valid_q;
  logic              ovf_q, unf_q;

  logic              wr_allow;
  logic              both_req;

  // Arbitration: prio_q = 0 prefers A, 1 prefers B. Contention only matters
  // when both request; a lone requester always wins if a slot is free.
  always_comb begin
    wr_allow = !full_q && !rst;
    both_req = wr_req_a && wr_req_b;
    wr_gnt_a = wr_allow && wr_req_a && (!wr_req_b || !prio_q);
    wr_gnt_b = wr_allow && wr_req_b && (!wr_req_a ||  prio_q);
  end

  assign write_enable = wr_gnt_a | wr_gnt_b;
  assign write_addr   = wr_ptr_q;
  assign write_data   = wr_gnt_b ? wr_data_b : wr_data_a;
  assign read_enable  = rd_req && !empty_q && !rst;
  assign read_addr    = rd_ptr_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    prio_d   = prio_q;

    if (write_enable) wr_ptr_d = wr_ptr_q + 1'b1;
    if (read_enable)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (write_enable && !read_enable)      count_d = count_q + 1'b1;
    else if (read_enable && !write_enable) count_d = count_q - 1'b1;

    // After a contested grant, hand preference to the loser (A won -> prefer B).
    if (both_req && write_enable) prio_d = wr_gnt_a;

    // Flags come from the next count so they are exact right after the edge.
    full_d  = (count_d == (ADDR_W+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      prio_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      prio_q     <= prio_d;
      // The array registers read_data on the same edge read_enable is seen.
      rd_valid_q <= read_enable;
      ovf_q      <= (wr_req_a | wr_req_b) && full_q;
      unf_q      <= rd_req && empty_q;
    end
  end

  assign rd_valid = rd_valid_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_req_a, wr_req_b, rd_req;
  logic [7:0] wr_data_a, wr_data_b;
  logic       wr_gnt_a, wr_gnt_b, rd_valid;
  logic       write_enable, read_enable;
  logic [2:0] write_addr, read_addr;
  logic [7:0] write_data;
  logic       full, empty, ovf, unf;
  logic [3:0] count;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst),
    .wr_req_a(wr_req_a), .wr_data_a(wr_data_a), .wr_gnt_a(wr_gnt_a),
    .wr_req_b(wr_req_b), .wr_data_b(wr_data_b), .wr_gnt_b(wr_gnt_b),
    .rd_req(rd_req), .rd_valid(rd_valid),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .read_enable(read_enable), .read_addr(read_addr),
    .full(full), .empty(empty), .count(count), .ovf(ovf), .unf(unf)
  );

  // Behavioural register array with registered read, as the controller expects.
  logic [7:0] mem [8];
  logic [7:0] read_data;
  always @(posedge clk) begin
    if (write_enable) mem[write_addr] <= write_data;
    if (read_enable)  read_data <= mem[read_addr];
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_q [$];

  typedef struct {
    logic       rst;
    logic       ra;
    logic [7:0] da;
    logic       rb;
    logic [7:0] db;
    logic       rr;
    logic       ga;
    logic       gb;
    logic       re;
    int         cnt;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check combinational outputs, then registered
  // outputs after the edge. Expected write data is queued from the bench's own
  // expected grant; pops are compared against the array model's read_data.
  task automatic step(input vec_t v);
    logic [7:0] exp_d;
    rst = v.rst; wr_req_a = v.ra; wr_data_a = v.da;
    wr_req_b = v.rb; wr_data_b = v.db; rd_req = v.rr;
    #1;
    chk("wr_gnt_a", int'(wr_gnt_a), int'(v.ga));
    chk("wr_gnt_b", int'(wr_gnt_b), int'(v.gb));
    chk("read_enable", int'(read_enable), int'(v.re));
    chk("write_enable", int'(write_enable), int'(v.ga | v.gb));
    if (v.ga) sb_q.push_back(v.da);
    else if (v.gb) sb_q.push_back(v.db);
    @(posedge clk); #1;
    chk("count", int'(count), v.cnt);
    chk("full", int'(full), int'(v.cnt == 8));
    chk("empty", int'(empty), int'(v.cnt == 0));
    chk("ovf", int'(ovf), int'(v.ovf));
    chk("unf", int'(unf), int'(v.unf));
    chk("rd_valid", int'(rd_valid), int'(v.re));
    if (rd_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_underrun", 1, 0);
      end else begin
        exp_d = sb_q.pop_front();
        chk("read_data", int'(read_data), int'(exp_d));
      end
    end
    $display("t=%0t rst=%0b ra=%0b rb=%0b rr=%0b ga=%0b gb=%0b re=%0b cnt=%0d rv=%0b rdata=%02h",
             $time, v.rst, v.ra, v.rb, v.rr, wr_gnt_a, wr_gnt_b, read_enable, count, rd_valid, read_data);
    @(negedge clk);
  endtask

  function automatic vec_t mk(logic r, logic ra, logic [7:0] da, logic rb, logic [7:0] db,
                              logic rr, logic ga, logic gb, logic re, int cnt,
                              logic o, logic u);
    vec_t v;
    v.rst = r; v.ra = ra; v.da = da; v.rb = rb; v.db = db; v.rr = rr;
    v.ga = ga; v.gb = gb; v.re = re; v.cnt = cnt; v.ovf = o; v.unf = u;
    return v;
  endfunction

  task automatic do_reset();
    sb_q.delete();
    step(mk(1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; wr_req_a = 0; wr_req_b = 0; rd_req = 0;
    wr_data_a = 0; wr_data_b = 0;
    @(negedge clk);

    // Table: reset behaviour, fill, overflow, drain, underflow.
    tbl.push_back(mk(1, 1, 8'h55, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h00, 1, 8'h66, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 8'(8'h10 + i), 0, 8'h00, 0, 1, 0, 0, i + 1, 0, 0));
    tbl.push_back(mk(0, 1, 8'h18, 0, 8'h00, 0, 0, 0, 0, 8, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 7 - i, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) step(tbl[i]);

    // Round-robin: contested grants alternate A,B,...; a lone B keeps prio.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(mk(0, 1, 8'hA0, 1, 8'hB0, 0, (i % 2) == 0, (i % 2) == 1, 0, i + 1, 0, 0));
    step(mk(0, 0, 8'h00, 1, 8'hB1, 0, 0, 1, 0, 5, 0, 0));
    step(mk(0, 1, 8'hA1, 1, 8'hB2, 0, 1, 0, 0, 6, 0, 0));
    for (int i = 0; i < 6; i++)
      step(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 5 - i, 0, 0));

    // Wrap-around: preload 4, then 12 cycles of simultaneous write and read.
    do_reset();
    for (int i = 0; i < 4; i++)
      step(mk(0, 1, 8'(8'h01 + i), 0, 8'h00, 0, 1, 0, 0, i + 1, 0, 0));
    for (int i = 0; i < 12; i++)
      step(mk(0, 1, 8'(8'h20 + i), 0, 8'h00, 1, 1, 0, 1, 4, 0, 0));
    for (int i = 0; i < 4; i++)
      step(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 3 - i, 0, 0));

    // Full plus read: write refused with ovf, read proceeds, count drops to 7.
    do_reset();
    for (int i = 0; i < 8; i++)
      step(mk(0, 0, 8'h00, 1, 8'(8'h30 + i), 0, 0, 1, 0, i + 1, 0, 0));
    step(mk(0, 1, 8'h3F, 0, 8'h00, 1, 0, 0, 1, 7, 1, 0));
    step(mk(0, 1, 8'h40, 0, 8'h00, 0, 1, 0, 0, 8, 0, 0));
    for (int i = 0; i < 8; i++)
      step(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 7 - i, 0, 0));

    // Mid-stream reset at count 5, then write+read on empty (no bypass).
    do_reset();
    for (int i = 0; i < 5; i++)
      step(mk(0, 1, 8'(8'h50 + i), 0, 8'h00, 0, 1, 0, 0, i + 1, 0, 0));
    do_reset();
    step(mk(0, 1, 8'h77, 0, 8'h00, 1, 1, 0, 0, 1, 0, 1));
    step(mk(0, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 0, 0, 0));
    step(mk(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0));

    chk("sb_leftover", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
